gtech_and_tree_pipe: RTL and testbench

GTECH_AND_TREE_PIPE -- requirements
Module: gtech_and_tree_pipe

---
 rtl/gtech_and_tree_pipe.sv | 51 +++++
 tb/tb_gtech_and_tree_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gtech_and_tree_pipe.sv
// gtech_and_tree_pipe: pipelined binary AND-reduction tree with per-stage valid/ready handshake.
// Define GTECH_AND_TREE_ZCNT_EN to add ZCNT, a saturating count of delivered Z = 0 results.
module gtech_and_tree_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             CP,
  input  logic             R,
  input  logic [WIDTH-1:0] A,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             Z,
  output logic             OUT_VALID,
  input  logic             OUT_READY
`ifdef GTECH_AND_TREE_ZCNT_EN
  ,
  output logic [15:0]      ZCNT
`endif
);
  localparam int STAGES = $clog2(WIDTH);
  // Heap-ordered tree: node n has children 2n and 2n+1; nodes WIDTH.. are the live inputs,
  // nodes 1..WIDTH-1 are registers, stage k holding nodes WIDTH>>k .. (WIDTH>>(k-1))-1.
  logic [WIDTH-1:1]   q;
  logic [2*WIDTH-1:1] t;
  logic [STAGES:1]    v;
  logic [STAGES:1]    vin;
  logic [STAGES+1:1]  r;
  assign t = {A, q};
  assign vin = (v << 1) | STAGES'(IN_VALID);
  always_comb begin
    r[STAGES+1] = OUT_READY;
    for (int k = STAGES; k >= 1; k--) r[k] = ~v[k] | r[k+1];
  end
  always_ff @(posedge CP)
    if (R) begin
      q <= '0;
      v <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) if (r[k]) v[k] <= vin[k];
      for (int n = 1; n < WIDTH; n++)
        for (int k = 1; k <= STAGES; k++)
          if (r[k] && n >= (WIDTH >> k) && n < (WIDTH >> (k - 1))) q[n] <= t[2*n] & t[2*n+1];
    end
  assign IN_READY = r[1] | R;
  assign OUT_VALID = v[STAGES] & ~R;
  assign Z = t[1] & ~R;
`ifdef GTECH_AND_TREE_ZCNT_EN
  always_ff @(posedge CP)
    if (R) ZCNT <= '0;
    else if (OUT_VALID && OUT_READY && !Z && ZCNT != 16'hFFFF) ZCNT <= ZCNT + 16'd1;
`endif
endmodule

// File: tb/tb_gtech_and_tree_pipe.sv
// tb_gtech_and_tree_pipe: directed stimulus plus a queue-based reference of the AND pipeline.
// The reference holds accepted operands in order; Z must equal the AND of the oldest one.
module tb_gtech_and_tree_pipe;
  localparam int W = 8;
  localparam int S = 3;
  logic CP = 1'b0;
  logic R, IN_VALID, OUT_READY, IN_READY, Z, OUT_VALID;
  logic [W-1:0] A;
`ifdef GTECH_AND_TREE_ZCNT_EN
  logic [15:0] ZCNT;
`endif
  gtech_and_tree_pipe #(.WIDTH(W)) dut (
    .CP(CP), .R(R), .A(A), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .Z(Z), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
`ifdef GTECH_AND_TREE_ZCNT_EN
    , .ZCNT(ZCNT)
`endif
  );
  always #5 CP = ~CP;
  typedef struct {logic [W-1:0] a; int ac;} item_t;
  item_t mq[$];
  logic out_z[$];
  int out_cyc[$];
  int pass_n = 0, tot_n = 0, cyc = 0, last_stall = 0;
  logic [W-1:0] vec[8];
  logic ez[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  // Reference: occupancy decides readiness, FIFO order decides Z, clean flow fixes latency.
  always @(negedge CP) begin
    item_t e;
    cyc++;
    if (R) begin
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_z", Z, 0);
      chk("rst_in_ready", IN_READY, 1);
      mq.delete();
    end else begin
      chk("in_ready_rule", IN_READY, OUT_READY || mq.size() < S);
      if (mq.size() == 0) chk("empty_out_valid", OUT_VALID, 0);
      if (!OUT_READY) last_stall = cyc;
      if (OUT_VALID && OUT_READY) begin
        chk("out_has_item", mq.size() > 0, 1);
        if (mq.size() > 0) begin
          e = mq.pop_front();
          chk("z_value", Z, &e.a);
          if (last_stall <= e.ac) chk("latency", cyc - e.ac, S);
          else chk("latency_min", cyc - e.ac >= S, 1);
          out_z.push_back(Z);
          out_cyc.push_back(cyc);
        end
      end
      if (IN_VALID && IN_READY) mq.push_back('{A, cyc});
    end
  end
  task automatic step();
    @(posedge CP);
    #1;
  endtask
  task automatic clear_log();
    out_z.delete();
    out_cyc.delete();
  endtask
  task automatic check_log(input string nm, input int n);
    chk({nm, "_count"}, out_z.size(), n);
    for (int i = 0; i < n; i++) if (i < out_z.size()) chk({nm, "_z"}, out_z[i], ez[i]);
  endtask
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", pass_n, tot_n);
    $fatal(1);
  end
  initial begin
    int start, idx;
    logic acc;
    R = 1; IN_VALID = 0; OUT_READY = 1; A = '0;
    repeat (2) step();
    R = 0;
    @(negedge CP);
    chk("post_rst_out_valid", OUT_VALID, 0);
    chk("post_rst_in_ready", IN_READY, 1);
    step();
    // Clean stream: latency 3, throughput 1
    clear_log();
    vec = '{8'hFF, 8'hFE, 8'h7F, 8'hFF, 0, 0, 0, 0};
    ez = '{1, 0, 0, 1, 0, 0, 0, 0};
    start = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      A = vec[i]; IN_VALID = 1;
      @(negedge CP);
      chk("stream_in_ready", IN_READY, 1);
      step();
    end
    IN_VALID = 0;
    repeat (6) step();
    check_log("stream", 4);
    for (int i = 0; i < 4; i++) if (i < out_cyc.size()) chk("stream_cycle", out_cyc[i] - start, 3 + i);
    // Full stall: three buffered, then drain in order
    clear_log();
    vec = '{8'hFF, 8'h01, 8'hFF, 8'h80, 8'hFF, 0, 0, 0};
    ez = '{1, 0, 1, 0, 1, 0, 0, 0};
    OUT_READY = 0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      A = vec[idx]; IN_VALID = 1;
      @(negedge CP);
      acc = IN_READY;
      step();
      if (acc) idx++;
    end
    chk("stall_accepted", idx, 3);
    @(negedge CP);
    chk("stall_in_ready", IN_READY, 0);
    step();
    OUT_READY = 1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      A = vec[idx];
      @(negedge CP);
      acc = IN_READY;
      step();
      if (acc) idx++;
    end
    IN_VALID = 0;
    chk("stall_all_sent", idx, 5);
    repeat (6) step();
    check_log("stall", 5);
    // Bubble collapse behind a stalled head
    clear_log();
    ez = '{1, 0, 0, 0, 0, 0, 0, 0};
    OUT_READY = 0;
    A = 8'hFF; IN_VALID = 1;
    @(negedge CP);
    chk("bubble_first_in_ready", IN_READY, 1);
    step();
    A = 8'h00;
    @(negedge CP);
    chk("bubble_second_in_ready", IN_READY, 1);
    step();
    IN_VALID = 0;
    repeat (3) step();
    OUT_READY = 1;
    repeat (4) step();
    check_log("bubble", 2);
    if (out_cyc.size() == 2) chk("bubble_back_to_back", out_cyc[1] - out_cyc[0], 1);
    // Reset with two operands in flight; A offered during reset must be ignored
    clear_log();
    A = 8'h00; IN_VALID = 1;
    step();
    A = 8'hFF;
    step();
    R = 1; A = 8'h00;
    step();
    R = 0; IN_VALID = 0;
    @(negedge CP);
    chk("after_rst_out_valid", OUT_VALID, 0);
    chk("after_rst_in_ready", IN_READY, 1);
    step();
    repeat (5) step();
    chk("after_rst_no_output", out_z.size(), 0);
    A = 8'hFF; IN_VALID = 1;
    step();
    IN_VALID = 0;
    repeat (5) step();
    ez = '{1, 0, 0, 0, 0, 0, 0, 0};
    check_log("post_rst_op", 1);
    // Continuous 20-operand stream, no stalls
    clear_log();
    OUT_READY = 1;
    for (int i = 0; i < 20; i++) begin
      A = (i % 3 == 0) ? 8'hFF : (8'hFF ^ (8'h01 << (i % 8)));
      IN_VALID = 1;
      @(negedge CP);
      chk("burst_in_ready", IN_READY, 1);
      step();
    end
    IN_VALID = 0;
    repeat (6) step();
    chk("burst_count", out_z.size(), 20);
`ifdef GTECH_AND_TREE_ZCNT_EN
    R = 1;
    step();
    R = 0;
    chk("zcnt_reset", ZCNT, 0);
    clear_log();
    A = 8'h00; IN_VALID = 1;
    repeat (10) step();
    A = 8'hFF;
    step();
    IN_VALID = 0;
    repeat (6) step();
    chk("zcnt_ten", ZCNT, 10);
    clear_log();
    A = 8'h00; IN_VALID = 1;
    repeat (70000) step();
    IN_VALID = 0;
    repeat (6) step();
    chk("zcnt_saturated", ZCNT, 16'hFFFF);
    R = 1;
    step();
    R = 0;
    chk("zcnt_cleared", ZCNT, 0);
`endif
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
